neuron_layer_feeder: RTL

- Memory/sequencing side of the neuron read interface: the responder that serves operands to a neuron controller and collects its result.
- Buffers one input vector from upstream and holds an M x N weight array.
- For each of M neurons in turn: pulses start, answers read/offset requests with input and weight operands, captures the result on ready, then streams it downstream.
- Sits between the input stream and the neuron datapath/controller of one layer.

---
 rtl/neuron_pkg.sv | 21 ++
 rtl/feeder_operand_store.sv | 70 +++++++
 rtl/neuron_layer_feeder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron layer feeder: FSM encoding, default
// geometry and an index-width helper.
package neuron_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] SERVE = 3'd3;
  localparam logic [2:0] EMIT  = 3'd4;

  localparam int DEF_N  = 10;
  localparam int DEF_M  = 4;
  localparam int DEF_DW = 8;
  localparam int DEF_RW = 20;

  // Index width for a table of the given depth, never narrower than one bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/feeder_operand_store.sv
// Input-vector buffer and M x N weight array with a registered x/w read port.
module feeder_operand_store
  import neuron_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int M  = DEF_M,
  parameter int DW = DEF_DW,
  parameter int AW = idx_width(DEF_N),
  parameter int MW = idx_width(DEF_M)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          x_we,
  input  logic [AW-1:0] x_idx,
  input  logic [DW-1:0] x_wdata,
  input  logic          w_we,
  input  logic [MW-1:0] w_nidx,
  input  logic [AW-1:0] w_off,
  input  logic [DW-1:0] w_wdata,
  input  logic          rd_en,
  input  logic [MW-1:0] rd_nidx,
  input  logic [AW-1:0] rd_off,
  output logic [DW-1:0] rd_x,
  output logic [DW-1:0] rd_w,
  output logic          rd_oor
);

  logic [DW-1:0] x_buf_q [N];
  logic [DW-1:0] w_arr_q [M][N];
  logic [DW-1:0] rd_x_d, rd_x_q;
  logic [DW-1:0] rd_w_d, rd_w_q;

  assign rd_oor = (int'(rd_off) >= N);

  // Storage is intentionally not reset; weights must survive a layer reset.
  always_ff @(posedge clk) begin
    if (x_we && int'(x_idx) < N)
      x_buf_q[x_idx] <= x_wdata;
    if (w_we && int'(w_off) < N && int'(w_nidx) < M)
      w_arr_q[w_nidx][w_off] <= w_wdata;
  end

  always_comb begin
    rd_x_d = rd_x_q;
    rd_w_d = rd_w_q;
    if (rd_en) begin
      if (!rd_oor && int'(rd_nidx) < M) begin
        rd_x_d = x_buf_q[rd_off];
        rd_w_d = w_arr_q[rd_nidx][rd_off];
      end else begin
        rd_x_d = '0;
        rd_w_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_x_q <= '0;
      rd_w_q <= '0;
    end else begin
      rd_x_q <= rd_x_d;
      rd_w_q <= rd_w_d;
    end
  end

  assign rd_x = rd_x_q;
  assign rd_w = rd_w_q;

endmodule

// File: rtl/neuron_layer_feeder.sv
// Buffers one input vector, then serves operands to the neuron controller
// for each of M neurons in turn and streams each result downstream.
//
// state | meaning
// IDLE  | waiting for word 0 of the input vector; weight writes allowed
// LOAD  | accepting words 1..N-1 of the input vector
// START | one-cycle start pulse for neuron j
// SERVE | answering operand reads for neuron j, waiting for its result
// EMIT  | holding result j until downstream accepts it
module neuron_layer_feeder
  import neuron_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int M  = DEF_M,
  parameter int DW = DEF_DW,
  parameter int RW = DEF_RW,
  localparam int AW = idx_width(N),
  localparam int MW = idx_width(M)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic          w_we,
  input  logic [MW-1:0] w_nidx,
  input  logic [AW-1:0] w_off,
  input  logic [DW-1:0] w_wdata,
  output logic          n_start,
  input  logic          n_read,
  input  logic [AW-1:0] n_offset,
  output logic [DW-1:0] n_x,
  output logic [DW-1:0] n_w,
  input  logic          n_ready,
  input  logic [RW-1:0] n_result,
  output logic          out_valid,
  output logic [MW-1:0] out_nidx,
  output logic [RW-1:0] out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic          err
);

  logic [2:0]    state_d, state_q;
  logic [AW-1:0] load_cnt_d, load_cnt_q;
  logic [MW-1:0] j_d, j_q;
  logic [RW-1:0] out_data_d, out_data_q;
  logic [MW-1:0] out_nidx_d, out_nidx_q;
  logic          err_d, err_q;

  logic          accept;
  logic          x_we;
  logic [AW-1:0] x_idx;
  logic          w_we_ok;
  logic          rd_en;
  logic          rd_oor;

  assign in_ready  = !rst && (state_q == IDLE || state_q == LOAD);
  assign accept    = in_valid && in_ready;
  assign n_start   = (state_q == START);
  assign out_valid = (state_q == EMIT);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_data_q;
  assign out_nidx  = out_nidx_q;
  assign err       = err_q;

  // A read issued in the START cycle is served as if already in SERVE.
  assign rd_en   = n_read && (state_q == START || state_q == SERVE);
  assign w_we_ok = w_we && (state_q == IDLE);

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    j_d        = j_q;
    out_data_d = out_data_q;
    out_nidx_d = out_nidx_q;
    x_we       = 1'b0;
    x_idx      = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          x_we = 1'b1;
          if (N == 1) begin
            state_d = START;
            j_d     = '0;
          end else begin
            state_d    = LOAD;
            load_cnt_d = AW'(1);
          end
        end
      end
      LOAD: begin
        if (accept) begin
          x_we  = 1'b1;
          x_idx = load_cnt_q;
          if (load_cnt_q == AW'(N - 1)) begin
            state_d    = START;
            load_cnt_d = '0;
            j_d        = '0;
          end else begin
            load_cnt_d = load_cnt_q + AW'(1);
          end
        end
      end
      START: state_d = SERVE;
      SERVE: begin
        if (n_ready) begin
          out_data_d = n_result;
          out_nidx_d = j_q;
          state_d    = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (j_q == MW'(M - 1)) begin
            state_d = IDLE;
            j_d     = '0;
          end else begin
            state_d = START;
            j_d     = j_q + MW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    err_d = err_q
          | (w_we && state_q != IDLE)
          | (n_read && !rd_en)
          | (n_ready && state_q != SERVE)
          | (rd_en && rd_oor);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      load_cnt_q <= '0;
      j_q        <= '0;
      out_data_q <= '0;
      out_nidx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      j_q        <= j_d;
      out_data_q <= out_data_d;
      out_nidx_q <= out_nidx_d;
      err_q      <= err_d;
    end
  end

  feeder_operand_store #(
    .N  (N),
    .M  (M),
    .DW (DW),
    .AW (AW),
    .MW (MW)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .x_we    (x_we),
    .x_idx   (x_idx),
    .x_wdata (in_data),
    .w_we    (w_we_ok),
    .w_nidx  (w_nidx),
    .w_off   (w_off),
    .w_wdata (w_wdata),
    .rd_en   (rd_en),
    .rd_nidx (j_q),
    .rd_off  (n_offset),
    .rd_x    (n_x),
    .rd_w    (n_w),
    .rd_oor  (rd_oor)
  );

endmodule
